// File: rtl/noc_rx_endpoint.sv
// Receive-side NoC endpoint: captures packets, checks the destination address, queues accepted
// payloads in a small FIFO and answers the sender with a one-cycle ack or nack.
module noc_rx_endpoint #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned ADDR_W  = 4,
  parameter int unsigned NODE_ID = 0,
  parameter int unsigned DEPTH   = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       pkt_valid,
  output logic                       pkt_ready,
  input  logic [ADDR_W-1:0]          pkt_dst,
  input  logic [DATA_W-1:0]          pkt_data,
  output logic                       ack,
  output logic                       nack,
  output logic                       dst_valid,
  input  logic                       dst_ready,
  output logic [DATA_W-1:0]          dst_data,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic [7:0]                 drop_cnt
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH+1);

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_CHECK = 2'd1,
    RX_RESP  = 2'd2
  } rx_state_t;

  rx_state_t          state;
  logic [ADDR_W-1:0]  hold_dst;
  logic [DATA_W-1:0]  hold_data;
  logic [DATA_W-1:0]  mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic               match;
  logic               wr_en;
  logic               rd_en;

  // Full check uses the occupancy at the start of the cycle, so a concurrent pop never frees space.
  always_comb begin
    match = (hold_dst == ADDR_W'(NODE_ID)) || (hold_dst == '1);
    wr_en = (state == RX_CHECK) && match && (count < CNT_W'(DEPTH));
    rd_en = (count != '0) && dst_ready;
  end

  assign dst_valid = (count != '0);
  assign dst_data  = mem[rd_ptr];

  // Receive FSM with registered handshake outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= RX_IDLE;
      pkt_ready <= 1'b0;
      ack       <= 1'b0;
      nack      <= 1'b0;
      drop_cnt  <= 8'd0;
      hold_dst  <= '0;
      hold_data <= '0;
    end else begin
      ack  <= 1'b0;
      nack <= 1'b0;
      case (state)
        RX_IDLE: begin
          pkt_ready <= 1'b1;
          if (pkt_valid && pkt_ready) begin
            hold_dst  <= pkt_dst;
            hold_data <= pkt_data;
            pkt_ready <= 1'b0;
            state     <= RX_CHECK;
          end
        end
        RX_CHECK: begin
          pkt_ready <= 1'b0;
          if (!match) begin
            nack  <= 1'b1;
            state <= RX_RESP;
            if (drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
          end else if (wr_en) begin
            ack   <= 1'b1;
            state <= RX_RESP;
          end
        end
        RX_RESP: begin
          pkt_ready <= 1'b1;
          state     <= RX_IDLE;
        end
        default: begin
          pkt_ready <= 1'b0;
          state     <= RX_IDLE;
        end
      endcase
    end
  end

  // FIFO pointers and occupancy; same-cycle push and pop leave count unchanged.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + PTR_W'(1);
      if (rd_en) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({wr_en, rd_en})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= hold_data;
  end

endmodule
